// File: rtl/sram_dump_unit_pkg.sv
// Shared defaults and FSM encoding for the SRAM readback engine.
// Optional trailing checksum byte is enabled with SRAM_DUMP_CSUM_EN.
package sram_dump_unit_pkg;

  localparam int WORD_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

endpackage

// File: rtl/sram_dump_csum.sv
// Running modular sum of dumped words; o_neg is the value that makes the
// whole stream sum to zero. Used only when SRAM_DUMP_CSUM_EN is defined.
module sram_dump_csum #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_add,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_neg
);

  logic [W-1:0] r_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= r_acc + i_data;
    end
  end

  assign o_neg = '0 - r_acc;

endmodule

// File: rtl/sram_dump_unit.sv
// Sequential SRAM window readback streamed over valid/ready.
// Define SRAM_DUMP_CSUM_EN to append a two's-complement checksum byte.
//
// Handshake: dout/dout_last are held while dout_valid=1 and dout_ready=0;
// a byte moves on a rising edge with dout_valid & dout_ready, and
// dout_valid never falls without such a transfer.
module sram_dump_unit
  import sram_dump_unit_pkg::*;
#(
  parameter int word_size = WORD_SIZE_DEF,
  parameter int addr_size = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [addr_size-1:0] first_addr,
  input  logic [addr_size-1:0] last_addr,
  output logic                 mem_rd,
  output logic [addr_size-1:0] mem_addr,
  input  logic [word_size-1:0] mem_data,
  output logic [word_size-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state
);

  localparam logic [addr_size-1:0] ADDR_ONE = {{(addr_size-1){1'b0}}, 1'b1};
  localparam logic [addr_size:0]   REM_ONE  = {{addr_size{1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_next;
  logic [addr_size-1:0]   r_addr;
  logic [addr_size-1:0]   r_mem_addr;
  logic [addr_size:0]     r_remaining;
  logic [word_size-1:0]   r_dout;
  logic                   r_done;
  logic [addr_size-1:0]   w_span;
  logic                   w_start;
  logic                   w_xfer;
  logic                   w_end;

  assign w_span  = last_addr - first_addr;
  assign w_start = (r_state == ST_IDLE) && start;
  assign w_xfer  = (r_state == ST_SEND) && dout_ready;

`ifdef SRAM_DUMP_CSUM_EN
  logic [word_size-1:0] w_csum;

  sram_dump_csum #(.W(word_size)) u_csum (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_start),
    .i_add   (w_xfer),
    .i_data  (r_dout),
    .o_neg   (w_csum)
  );

  assign w_end = (r_state == ST_CSUM) && dout_ready;
`else
  assign w_end = w_xfer && (r_remaining == REM_ONE);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_READ;
      ST_READ: w_next = ST_SEND;
      ST_SEND: begin
        if (dout_ready) begin
          if (r_remaining == REM_ONE) begin
`ifdef SRAM_DUMP_CSUM_EN
            w_next = ST_CSUM;
`else
            w_next = ST_IDLE;
`endif
          end else begin
            w_next = ST_READ;
          end
        end
      end
      ST_CSUM: if (dout_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_remaining <= '0;
      r_dout      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_end;
      if (w_start) begin
        r_addr      <= first_addr;
        r_remaining <= {1'b0, w_span} + REM_ONE;
      end
      if (r_state == ST_READ) begin
        r_dout     <= mem_data;
        r_mem_addr <= r_addr;
      end
      if (w_xfer) begin
        r_addr      <= r_addr + ADDR_ONE;
        r_remaining <= r_remaining - REM_ONE;
      end
    end
  end

  // Outside READ the address port keeps showing the last address read.
  assign mem_rd    = (r_state == ST_READ);
  assign mem_addr  = mem_rd ? r_addr : r_mem_addr;
  assign busy      = (r_state != ST_IDLE) || r_done;
  assign done      = r_done;
  assign dbg_state = r_state;

`ifdef SRAM_DUMP_CSUM_EN
  assign dout_valid = (r_state == ST_SEND) || (r_state == ST_CSUM);
  assign dout       = (r_state == ST_CSUM) ? w_csum : r_dout;
  assign dout_last  = (r_state == ST_CSUM);
`else
  assign dout_valid = (r_state == ST_SEND);
  assign dout       = r_dout;
  assign dout_last  = (r_state == ST_SEND) && (r_remaining == REM_ONE);
`endif

endmodule

// File: tb/tb_sram_dump_unit.sv
// Directed bench for sram_dump_unit: SRAM model, byte/address scoreboard,
// timing, stall, ignored start, and mid-dump reset scenarios.
module tb_sram_dump_unit;
  import sram_dump_unit_pkg::*;

  localparam int W = 8;
  localparam int A = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [A-1:0] first_addr;
  logic [A-1:0] last_addr;
  logic         mem_rd;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_data;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic         busy;
  logic         done;
  state_t       dbg_state;

  logic [W-1:0] mem [0:255];
  logic [W:0]   exp_q[$];
  logic [A-1:0] exp_addr_q[$];
  logic [W:0]   mon_e;
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;

  sram_dump_unit #(.word_size(W), .addr_size(A)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  assign mem_data = mem[mem_addr];

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      if (mem_rd) begin
        if (exp_addr_q.size() == 0) check("addr_unexpected", 32'(exp_addr_q.size()), 1);
        else check("mem_addr", mem_addr, exp_addr_q.pop_front());
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) check("byte_unexpected", 32'(exp_q.size()), 1);
        else begin
          mon_e = exp_q.pop_front();
          check("dout", dout, mon_e[W-1:0]);
          check("dout_last", dout_last, mon_e[W]);
        end
      end
      if (done) done_cnt++;
    end
  end

  // Driver tasks
  task automatic push_dump(input logic [A-1:0] f, input logic [A-1:0] l);
    logic [A-1:0] span;
    logic [A-1:0] a;
    logic [W-1:0] sum;
    int n;
    span = l - f;
    n = int'(span) + 1;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      a = f + A'(i);
      exp_addr_q.push_back(a);
`ifdef SRAM_DUMP_CSUM_EN
      exp_q.push_back({1'b0, mem[a]});
`else
      exp_q.push_back({(i == n - 1), mem[a]});
`endif
      sum = sum + mem[a];
    end
`ifdef SRAM_DUMP_CSUM_EN
    exp_q.push_back({1'b1, W'(0) - sum});
`endif
  endtask

  task automatic pulse_start(input logic [A-1:0] f, input logic [A-1:0] l);
    @(posedge clk); #1;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check({tag, "_busy_at_done"}, busy, 1);
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic finish_dump(input string tag, input int d0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 1);
    check({tag, "_bytes_left"}, 32'(exp_q.size()), 0);
    check({tag, "_addrs_left"}, 32'(exp_addr_q.size()), 0);
  endtask

  task automatic run_dump(input string tag, input logic [A-1:0] f, input logic [A-1:0] l);
    int d0;
    d0 = done_cnt;
    push_dump(f, l);
    pulse_start(f, l);
    wait_done(tag);
    finish_dump(tag, d0);
  endtask

  initial begin
    int d0;
    int sz0;
    logic hit;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[130] = 8'd10;  mem[131] = 8'd10;
    mem[139] = 8'hF0;
    mem[254] = 8'hA1;  mem[255] = 8'hB2;  mem[0] = 8'hC3;  mem[1] = 8'hD4;
    mem[140] = 8'h11;  mem[141] = 8'h22;  mem[142] = 8'h33;

    rst = 1'b1; start = 1'b0; dout_ready = 1'b1;
    first_addr = '0; last_addr = '0;
    #1 rst = 1'b0;
    #3;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout_last", dout_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single-byte window with cycle-exact timing
    d0 = done_cnt;
    push_dump(8'd139, 8'd139);
    pulse_start(8'd139, 8'd139);
    check("t_read_mem_rd", mem_rd, 1);
    check("t_read_addr", mem_addr, 139);
    check("t_read_busy", busy, 1);
    check("t_read_valid", dout_valid, 0);
    @(posedge clk); #1;
    check("t_send_valid", dout_valid, 1);
    check("t_send_dout", dout, 8'hF0);
    check("t_send_mem_rd", mem_rd, 0);
    check("t_send_addr_hold", mem_addr, 139);
`ifdef SRAM_DUMP_CSUM_EN
    check("t_send_last", dout_last, 0);
    wait_done("t1");
    finish_dump("t1", d0);
`else
    check("t_send_last", dout_last, 1);
    @(posedge clk); #1;
    check("t_done_high", done, 1);
    check("t_done_busy", busy, 1);
    check("t_done_valid", dout_valid, 0);
    @(posedge clk); #1;
    check("t_done_low", done, 0);
    check("t_idle_busy", busy, 0);
    check("t1_done_count", 32'(done_cnt - d0), 1);
`endif

    run_dump("w130", 8'd130, 8'd131);
    run_dump("wrap", 8'd254, 8'd1);

    // Back-pressure on the first byte
    d0 = done_cnt;
    push_dump(8'd140, 8'd142);
    dout_ready = 1'b0;
    pulse_start(8'd140, 8'd142);
    hit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (dout_valid) begin hit = 1'b1; break; end
    end
    check("stall_valid_seen", hit, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("stall_valid", dout_valid, 1);
      check("stall_dout", dout, 8'h11);
      check("stall_mem_rd", mem_rd, 0);
    end
    dout_ready = 1'b1;
    wait_done("stall");
    finish_dump("stall", d0);

    // Start during a dump must be ignored
    d0 = done_cnt;
    push_dump(8'd150, 8'd153);
    pulse_start(8'd150, 8'd153);
    repeat (3) @(posedge clk);
    #1;
    first_addr = 8'd10; last_addr = 8'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign");
    finish_dump("ign", d0);

    // Reset during the second SEND
    d0 = done_cnt;
    push_dump(8'd160, 8'd163);
    sz0 = exp_q.size();
    pulse_start(8'd160, 8'd163);
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (dout_valid && exp_q.size() == sz0 - 1) begin hit = 1'b1; break; end
    end
    check("rst2_second_send", hit, 1);
    #2 rst = 1'b0;
    #1;
    check("rst2_mem_rd", mem_rd, 0);
    check("rst2_mem_addr", mem_addr, 0);
    check("rst2_dout", dout, 0);
    check("rst2_valid", dout_valid, 0);
    check("rst2_last", dout_last, 0);
    check("rst2_busy", busy, 0);
    check("rst2_done", done, 0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_no_done", 32'(done_cnt - d0), 0);
    run_dump("after_rst", 8'd130, 8'd131);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
